// File: rtl/id_ex_stage_if.sv
// Decode-to-execute pipeline bus: upstream handshake + decoded payload, flush,
// and the downstream handshake + registered payload.
interface id_ex_stage_if #(
    parameter int DATA_W = 32
);
    logic              id_valid;
    logic              id_ready;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_rs1;
    logic [DATA_W-1:0] id_rs2;
    logic [DATA_W-1:0] id_imm;
    logic [4:0]        id_rd;
    logic [6:0]        id_op;
    logic [2:0]        id_f3;
    logic [3:0]        id_alu_op;
    logic              flush;
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_rs1;
    logic [DATA_W-1:0] ex_rs2;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_rd;
    logic [6:0]        ex_op;
    logic [2:0]        ex_f3;
    logic [3:0]        ex_alu_op;

    // Stage-side view.
    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_imm, id_rd, id_op, id_f3, id_alu_op,
        input  flush, ex_ready,
        output id_ready, ex_valid,
        output ex_pc, ex_rs1, ex_rs2, ex_imm, ex_rd, ex_op, ex_f3, ex_alu_op
    );

    // Environment-side view (decode driver + execute sink).
    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_imm, id_rd, id_op, id_f3, id_alu_op,
        output flush, ex_ready,
        input  id_ready, ex_valid,
        input  ex_pc, ex_rs1, ex_rs2, ex_imm, ex_rd, ex_op, ex_f3, ex_alu_op
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Default: single entry, id_ready = !ex_valid || ex_ready.
// Define ID_EX_SKID_BUF_EN for a two-entry skid buffer with a registered id_ready.
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    localparam int PW = 4*DATA_W + 19;

    logic [PW-1:0] in_w;
    logic [PW-1:0] out_q;
    logic          valid_q;
    logic          push;
    logic          pop;

    assign in_w = {bus.id_pc, bus.id_rs1, bus.id_rs2, bus.id_imm,
                   bus.id_rd, bus.id_op, bus.id_f3, bus.id_alu_op};
    assign {bus.ex_pc, bus.ex_rs1, bus.ex_rs2, bus.ex_imm,
            bus.ex_rd, bus.ex_op, bus.ex_f3, bus.ex_alu_op} = out_q;
    assign bus.ex_valid = valid_q;

    assign push = bus.id_valid && bus.id_ready;
    assign pop  = valid_q && bus.ex_ready;

`ifdef ID_EX_SKID_BUF_EN
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t        state_q;
    logic [PW-1:0] skid_q;
    logic          ready_q;

    assign bus.id_ready = ready_q;

    // ready_q mirrors "skid empty" so ex_ready never reaches id_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else if (bus.flush) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        out_q   <= in_w;
                        valid_q <= 1'b1;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_q <= in_w;
                    end else if (push) begin
                        skid_q  <= in_w;
                        ready_q <= 1'b0;
                        state_q <= FULL;
                    end else if (pop) begin
                        valid_q <= 1'b0;
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_q   <= skid_q;
                        ready_q <= 1'b1;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    logic [PW-1:0] out_d;
    logic          valid_d;

    assign bus.id_ready = !valid_q || bus.ex_ready;

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (bus.flush) begin
            out_d   = '0;
            valid_d = 1'b0;
        end else if (push) begin
            out_d   = in_w;
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end
`endif

endmodule
